uart_rx: RTL

//   UART receiver: the receive end of the link driven by uart_tx.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and bit-timing derivation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to idle-high.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= 2'b11;
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_frame_err
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CW    = $clog2(CPB);
    localparam int IW    = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF    = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rxs;
    logic                 shift_en;
    logic                 valid_nxt;
    logic                 ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_en;
    logic                 perr_nxt;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
        perr_nxt  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (!rxs) state_nxt = S_START;
            end
            S_START: begin
                // A start bit that has vanished by mid-bit is a glitch.
                if (cnt == HALF) state_nxt = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt == CNT_MAX) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx == IDX_MAX) state_nxt = S_PARITY;
`else
                    if (idx == IDX_MAX) state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == CNT_MAX) begin
                    par_en    = 1'b1;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop lets a back-to-back start bit be caught.
                if (cnt == CNT_MAX) begin
                    if (rxs) begin
                        valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt  = par_bit != ^shreg;
`endif
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= ferr_nxt;
            if (state_nxt != state || cnt == CNT_MAX) begin
                cnt <= '0;
            end else if (state != S_IDLE) begin
                cnt <= cnt + 1'b1;
            end
            if (state != S_DATA) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 1'b1;
            end
            if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (valid_nxt) rx_data <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_parity_err <= perr_nxt;
            if (par_en) par_bit <= rxs;
        end
    end
`endif

    assign rx_busy = state != S_IDLE;

endmodule
